// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg: shared FSM encoding and route-select helper for the stream crossbar.
package stream_xbar_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ROUTED = 2'd1, DRAIN = 2'd2} state_t;
   function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
      return sel < n;
   endfunction
endpackage

// File: rtl/cmn_EnResetReg.sv
// cmn_EnResetReg: enable-gated register with synchronous active-low reset.
module cmn_EnResetReg #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge clk) begin
      if (!reset) o_q <= RST_VAL;
      else if (i_en) o_q <= i_d;
   end
endmodule

// File: rtl/stream_inflight_counter.sv
// stream_inflight_counter: words accepted by the module but not yet returned,
// saturating at 0 (unsolicited output) and at MAX.
module stream_inflight_counter #(
   parameter int MAX = 4,
   localparam int CW = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);
   logic [CW-1:0] r_count;
   assign o_count = r_count;
   assign o_full  = r_count == CW'(MAX);
   assign o_empty = r_count == '0;
   always_ff @(posedge clk) begin
      if (!reset) r_count <= '0;
      else if (i_inc && !i_dec && !o_full) r_count <= r_count + 1'b1;
      else if (i_dec && !i_inc && !o_empty) r_count <= r_count - 1'b1;
   end
endmodule

// File: rtl/stream_xbar_ctrl.sv
// stream_xbar_ctrl: steers the adapter stream pair to one of N_MODULES accelerators,
// holding any reroute until the active module has returned all in-flight words.
module stream_xbar_ctrl
   import stream_xbar_pkg::*;
#(
   parameter int N_MODULES    = 2,
   parameter int DATA_W       = 32,
   parameter int MAX_INFLIGHT = 4,
   localparam int SEL_W = $clog2(N_MODULES)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SEL_W-1:0]              cfg_sel,
   input  logic                          cfg_val,
   output logic                          cfg_rdy,
   output logic                          cfg_err,
   input  logic                          up_i_val,
   output logic                          up_i_rdy,
   input  logic [DATA_W-1:0]             up_i_data,
   output logic                          up_o_val,
   input  logic                          up_o_rdy,
   output logic [DATA_W-1:0]             up_o_data,
   output logic [N_MODULES-1:0]          mod_i_val,
   input  logic [N_MODULES-1:0]          mod_i_rdy,
   output logic [N_MODULES*DATA_W-1:0]   mod_i_data,
   input  logic [N_MODULES-1:0]          mod_o_val,
   output logic [N_MODULES-1:0]          mod_o_rdy,
   input  logic [N_MODULES*DATA_W-1:0]   mod_o_data,
   output logic [SEL_W-1:0]              cur_sel,
   output logic                          busy
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   state_t        r_state;
   logic [CW-1:0] w_inflight;
   logic          w_full, w_empty, w_in_range, w_req, w_routed, w_live, w_inc, w_dec;
   assign w_in_range = sel_in_range(32'(cfg_sel), N_MODULES);
   assign w_req      = reset & cfg_val & w_in_range;
   assign cfg_err    = reset & cfg_val & ~w_in_range;
   assign cfg_rdy    = w_req & (r_state == IDLE || w_empty);
   assign w_routed   = r_state == ROUTED;
   assign w_live     = r_state != IDLE;
   assign busy       = !w_routed || !w_empty;
   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else
         unique case (r_state)
            IDLE:    r_state <= w_req ? ROUTED : IDLE;
            ROUTED:  r_state <= (w_req && !w_empty) ? DRAIN : ROUTED;
            DRAIN:   r_state <= (w_empty && (w_req || !cfg_val)) ? ROUTED : DRAIN;
            default: r_state <= IDLE;
         endcase
   end
   cmn_EnResetReg #(.W(SEL_W)) u_route (
      .clk(clk), .reset(reset), .i_en(cfg_rdy), .i_d(cfg_sel), .o_q(cur_sel)
   );
   // Input side only opens in ROUTED so DRAIN cannot grow the count it waits on.
   assign up_i_rdy   = w_routed & mod_i_rdy[cur_sel] & ~w_full;
   assign up_o_val   = w_live & mod_o_val[cur_sel];
   assign up_o_data  = mod_o_data[int'(cur_sel) * DATA_W +: DATA_W];
   assign mod_i_data = {N_MODULES{up_i_data}};
   always_comb begin
      mod_i_val = '0;
      mod_o_rdy = '0;
      mod_i_val[cur_sel] = w_routed & up_i_val & ~w_full;
      mod_o_rdy[cur_sel] = w_live & up_o_rdy;
   end
   assign w_inc = up_i_val & up_i_rdy;
   assign w_dec = up_o_val & up_o_rdy;
   stream_inflight_counter #(.MAX(MAX_INFLIGHT)) u_cnt (
      .clk(clk), .reset(reset), .i_inc(w_inc), .i_dec(w_dec),
      .o_count(w_inflight), .o_full(w_full), .o_empty(w_empty)
   );
endmodule

// File: tb/tb_stream_xbar_ctrl.sv
// tb_stream_xbar_ctrl: directed vectors for stream_xbar_ctrl with N_MODULES=3.
module tb_stream_xbar_ctrl;
   import stream_xbar_pkg::*;
   localparam int N = 3, DW = 32;
   logic          clk = 0, reset = 0;
   logic [1:0]    cfg_sel = '0, cur_sel;
   logic          cfg_val = 0, cfg_rdy, cfg_err;
   logic          up_i_val = 0, up_i_rdy, up_o_val, up_o_rdy = 0, busy;
   logic [DW-1:0] up_i_data = '0, up_o_data;
   logic [N-1:0]  mod_i_val, mod_i_rdy = '0, mod_o_val = '0, mod_o_rdy;
   logic [N*DW-1:0] mod_i_data, mod_o_data = '0;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   stream_xbar_ctrl #(.N_MODULES(N), .DATA_W(DW), .MAX_INFLIGHT(4)) dut (
      .clk(clk), .reset(reset), .cfg_sel(cfg_sel), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
      .cfg_err(cfg_err), .up_i_val(up_i_val), .up_i_rdy(up_i_rdy), .up_i_data(up_i_data),
      .up_o_val(up_o_val), .up_o_rdy(up_o_rdy), .up_o_data(up_o_data),
      .mod_i_val(mod_i_val), .mod_i_rdy(mod_i_rdy), .mod_i_data(mod_i_data),
      .mod_o_val(mod_o_val), .mod_o_rdy(mod_o_rdy), .mod_o_data(mod_o_data),
      .cur_sel(cur_sel), .busy(busy)
   );
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      step();
      step();
      chk("rst_cfg_rdy", 64'(cfg_rdy), 0);
      chk("rst_cfg_err", 64'(cfg_err), 0);
      chk("rst_busy", 64'(busy), 1);
      chk("rst_mod_i_val", 64'(mod_i_val), 0);
      chk("rst_mod_o_rdy", 64'(mod_o_rdy), 0);
      chk("rst_up_i_rdy", 64'(up_i_rdy), 0);
      chk("rst_up_o_val", 64'(up_o_val), 0);
      chk("rst_cur_sel", 64'(cur_sel), 0);
      chk("rst_state", 64'(dut.r_state), 64'(IDLE));
      reset = 1;
      // 1: first route, then a write reaches only module 1
      cfg_val = 1; cfg_sel = 1; #1;
      chk("t1_cfg_rdy", 64'(cfg_rdy), 1);
      step();
      cfg_val = 0;
      chk("t1_cur_sel", 64'(cur_sel), 1);
      up_i_val = 1; up_i_data = 32'hDEADBEEF; #1;
      chk("t1_mod_i_val", 64'(mod_i_val), 64'b010);
      chk("t1_mod_i_data", 64'(mod_i_data[DW +: DW]), 64'hDEADBEEF);
      up_i_val = 0;
      // 2: fill module 0 to MAX_INFLIGHT
      cfg_val = 1; cfg_sel = 0; #1;
      chk("t2_cfg_rdy", 64'(cfg_rdy), 1);
      step();
      cfg_val = 0;
      chk("t2_cur_sel", 64'(cur_sel), 0);
      mod_i_rdy = 3'b001; up_i_val = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_up_i_rdy", 64'(up_i_rdy), 1);
         step();
      end
      chk("t2_inflight", 64'(dut.w_inflight), 4);
      chk("t2_full_rdy", 64'(up_i_rdy), 0);
      chk("t2_full_val", 64'(mod_i_val), 0);
      up_i_val = 0;
      // 3: return 2 words, reroute with 2 in flight goes through DRAIN
      mod_o_val = 3'b001; up_o_rdy = 1;
      for (int i = 0; i < 2; i++) begin
         mod_o_data = {32'h0, 32'h0, 32'hA0 + 32'(i)}; #1;
         chk("t3_up_o_data", 64'(up_o_data), 64'hA0 + 64'(i));
         step();
      end
      mod_o_val = 0; up_o_rdy = 0;
      chk("t3_inflight2", 64'(dut.w_inflight), 2);
      cfg_val = 1; cfg_sel = 1; #1;
      chk("t3_cfg_rdy_hold", 64'(cfg_rdy), 0);
      step();
      chk("t3_state_drain", 64'(dut.r_state), 64'(DRAIN));
      up_i_val = 1; mod_i_rdy = 3'b111; #1;
      chk("t3_drain_up_i_rdy", 64'(up_i_rdy), 0);
      chk("t3_drain_mod_i_val", 64'(mod_i_val), 0);
      up_i_val = 0; mod_i_rdy = 3'b000;
      mod_o_val = 3'b001; up_o_rdy = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t3_drain_cfg_rdy", 64'(cfg_rdy), 0);
         chk("t3_drain_o_val", 64'(up_o_val), 1);
         step();
      end
      mod_o_val = 0; up_o_rdy = 0; #1;
      chk("t3_cfg_rdy", 64'(cfg_rdy), 1);
      step();
      cfg_val = 0; #1;
      chk("t3_cur_sel", 64'(cur_sel), 1);
      chk("t3_state", 64'(dut.r_state), 64'(ROUTED));
      chk("t3_busy", 64'(busy), 0);
      // 4: out-of-range select
      cfg_val = 1; cfg_sel = 3; #1;
      chk("t4_cfg_err", 64'(cfg_err), 1);
      chk("t4_cfg_rdy", 64'(cfg_rdy), 0);
      step();
      cfg_val = 0; #1;
      chk("t4_err_pulse", 64'(cfg_err), 0);
      chk("t4_cur_sel", 64'(cur_sel), 1);
      chk("t4_state", 64'(dut.r_state), 64'(ROUTED));
      // 5: simultaneous in/out fire at inflight=2
      cfg_val = 1; cfg_sel = 0; step();
      cfg_val = 0; mod_i_rdy = 3'b001; up_i_val = 1;
      step(); step();
      chk("t5_inflight2", 64'(dut.w_inflight), 2);
      mod_o_val = 3'b001; up_o_rdy = 1;
      mod_o_data = {32'h33333333, 32'h22222222, 32'h11111111}; #1;
      chk("t5_up_o_data", 64'(up_o_data), 64'h11111111);
      chk("t5_both_fire", 64'({up_i_rdy, up_o_val}), 64'b11);
      step();
      chk("t5_inflight", 64'(dut.w_inflight), 2);
      mod_o_val = 0; up_o_rdy = 0;
      // 6: reset while draining with 3 in flight
      step();
      up_i_val = 0;
      chk("t6_inflight3", 64'(dut.w_inflight), 3);
      cfg_val = 1; cfg_sel = 2; step();
      cfg_val = 0;
      chk("t6_drain", 64'(dut.r_state), 64'(DRAIN));
      reset = 0; mod_o_val = 3'b111; up_o_rdy = 1; up_i_val = 1; mod_i_rdy = 3'b111;
      step();
      chk("t6_state", 64'(dut.r_state), 64'(IDLE));
      chk("t6_inflight", 64'(dut.w_inflight), 0);
      chk("t6_mod_i_val", 64'(mod_i_val), 0);
      chk("t6_mod_o_rdy", 64'(mod_o_rdy), 0);
      chk("t6_up_o_val", 64'(up_o_val), 0);
      chk("t6_cur_sel", 64'(cur_sel), 0);
      chk("t6_busy", 64'(busy), 1);
      mod_o_val = 0; up_o_rdy = 0; up_i_val = 0; mod_i_rdy = 0;
      reset = 1;
      // unsolicited output at inflight=0 must not underflow
      cfg_val = 1; cfg_sel = 2; step();
      cfg_val = 0;
      chk("t7_cur_sel", 64'(cur_sel), 2);
      mod_o_val = 3'b100; up_o_rdy = 1; #1;
      chk("t7_up_o_val", 64'(up_o_val), 1);
      chk("t7_mod_o_rdy", 64'(mod_o_rdy), 64'b100);
      step();
      chk("t7_no_underflow", 64'(dut.w_inflight), 0);
      mod_o_val = 0; up_o_rdy = 0; up_i_val = 1; mod_i_rdy = 3'b100;
      step();
      up_i_val = 0;
      chk("t7_inflight1", 64'(dut.w_inflight), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
